// File: rtl/ifetch_ctrl_if.sv
// Icache request/response bundle between the fetch sequencer and the instruction cache.
interface ifetch_ctrl_if;
    logic [31:0] icache_pcin;
    logic        icache_ren;
    logic        icache_abort;
    logic        icache_dout_valid;

    // Fetch sequencer drives the request side.
    modport master (
        output icache_pcin,
        output icache_ren,
        output icache_abort,
        input  icache_dout_valid
    );

    // Instruction cache answers with line-valid.
    modport slave (
        input  icache_pcin,
        input  icache_ren,
        input  icache_abort,
        output icache_dout_valid
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: issues 16-byte icache line reads, tracks free IFQ line slots with a
// credit counter, cancels outstanding reads on redirect or watchdog timeout, and forwards
// only non-stale responses to the IFQ as line-write strobes.
module ifetch_ctrl #(
    parameter int unsigned LINES    = 4,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_addr,
    input  logic                         line_pop,
    ifetch_ctrl_if.master                ic,
    output logic                         fill_valid,
    output logic [31:0]                  fill_pc,
    output logic [$clog2(LINES+1)-1:0]   credits,
    output logic                         busy
);

    localparam int unsigned CW = $clog2(LINES + 1);
    localparam int unsigned WW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] CreditsMax = CW'(LINES);
    localparam logic [WW-1:0] WaitLast   = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StAbort = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] credits_q, credits_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;

    // Credit count after this cycle's fill and pop; pops at full capacity saturate.
    logic [CW-1:0] credits_upd;

    // Low nibble of the redirect target only selects a byte within the line.
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_addr[3:0];

    // Moore outputs from state, plus the one combinational accept strobe.
    always_comb begin
        ic.icache_ren   = (state_q == StWait);
        ic.icache_abort = (state_q == StAbort);
        ic.icache_pcin  = fetch_pc_q;
        fill_pc         = fetch_pc_q;
        busy            = (state_q == StWait);
        credits         = credits_q;
        // A redirect in the same cycle makes the arriving line stale.
        fill_valid      = (state_q == StWait) & ic.icache_dout_valid & ~redirect_valid;
    end

    // Credit arithmetic: consume on fill, return on pop, never exceed LINES.
    always_comb begin
        credits_upd = credits_q;
        if (fill_valid) begin
            credits_upd = credits_upd - CW'(1);
        end
        if (line_pop && (credits_upd != CreditsMax)) begin
            credits_upd = credits_upd + CW'(1);
        end
    end

    // Next-state logic; redirect overrides everything, including pops and responses.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        credits_d  = credits_upd;
        wait_cnt_d = wait_cnt_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_addr[31:4], 4'h0};
            credits_d  = CreditsMax;
            wait_cnt_d = '0;
            // Only an outstanding read needs an explicit cancel.
            state_d    = (state_q == StWait) ? StAbort : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (credits_q != '0) begin
                        state_d    = StWait;
                        wait_cnt_d = '0;
                    end
                end
                StWait: begin
                    if (ic.icache_dout_valid) begin
                        fetch_pc_d = fetch_pc_q + 32'd16;
                        wait_cnt_d = '0;
                        // Back-to-back issue while the IFQ still has room.
                        state_d    = (credits_upd != '0) ? StWait : StIdle;
                    end else if (wait_cnt_q == WaitLast) begin
                        // fetch_pc is kept so the same line is retried.
                        state_d = StAbort;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
                StAbort: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            credits_q  <= CreditsMax;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            credits_q  <= credits_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule
